// File: rtl/muldiv_seq.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) unit.
// One iteration per cycle; R/flags are registered and change only on entry to DONE.
module muldiv_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 op_div,
  input  logic [2*WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]     B,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   R,
  output logic [3:0]           flags
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e               state_q;
  logic                 op_q;
  logic [WIDTH-1:0]     opnd_q;   // MUL: multiplicand, DIV: divisor
  logic [2*WIDTH-1:0]   acc_q;    // MUL: {partial, multiplier}, DIV: {rem, quo}
  logic [2*WIDTH-1:0]   acc_d;
  logic [CW-1:0]        cnt_q;
  logic                 ready_q, busy_q, done_q;
  logic [2*WIDTH-1:0]   r_q;
  logic [3:0]           flags_q;

  logic [WIDTH:0]       add_sum;
  logic [2*WIDTH:0]     shl;
  logic [WIDTH:0]       trial;
  logic [WIDTH:0]       diff;

  always_comb begin
    acc_d   = acc_q;
    add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    shl     = {acc_q, 1'b0};
    trial   = shl[2*WIDTH:WIDTH];
    diff    = trial - {1'b0, opnd_q};
    if (!op_q) begin
      if (acc_q[0]) add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
      acc_d = {add_sum, acc_q[WIDTH-1:1]};
    end else if (trial >= {1'b0, opnd_q}) begin
      // remainder stays below the divisor, so the difference fits in WIDTH bits
      acc_d = {diff[WIDTH-1:0], shl[WIDTH-1:1], 1'b1};
    end else begin
      acc_d = shl[2*WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r_q     <= '0;
      flags_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            op_q  <= op_div;
            cnt_q <= CW'(WIDTH);
            if (op_div) begin
              acc_q  <= A;
              opnd_q <= B;
            end else begin
              acc_q  <= {{WIDTH{1'b0}}, B};
              opnd_q <= A[WIDTH-1:0];
            end
            if (op_div && (B == '0)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              r_q     <= A;
              flags_q <= 4'b1100;
            end else if (op_div && (A[2*WIDTH-1:WIDTH] >= B)) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              r_q     <= A;
              flags_q <= {A[WIDTH-1], 1'b1, 1'b0, (A == '0)};
            end else begin
              state_q <= S_BUSY;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end
          end else begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_BUSY: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            r_q     <= acc_d;
            flags_q <= {(op_q ? acc_d[WIDTH-1] : acc_d[2*WIDTH-1]), 1'b0, 1'b0,
                        (acc_d == '0)};
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign R     = r_q;
  assign flags = flags_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq at WIDTH=8 and WIDTH=16 with directed vectors.
module tb_muldiv_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    int          cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;

  logic        start8 = 1'b0, op8 = 1'b0;
  logic [15:0] A8 = '0;
  logic [7:0]  B8 = '0;
  logic        ready8, busy8, done8;
  logic [15:0] R8;
  logic [3:0]  flags8;

  logic        start16 = 1'b0, op16 = 1'b0;
  logic [31:0] A16 = '0;
  logic [15:0] B16 = '0;
  logic        ready16, busy16, done16;
  logic [31:0] R16;
  logic [3:0]  flags16;

  muldiv_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op_div(op8), .A(A8), .B(B8),
    .ready(ready8), .busy(busy8), .done(done8), .R(R8), .flags(flags8)
  );

  muldiv_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op_div(op16), .A(A16), .B(B16),
    .ready(ready16), .busy(busy16), .done(done16), .R(R16), .flags(flags16)
  );

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cyc %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(negedge clk) begin
    if (!reset && done8) begin
      if (q8.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL w8_unexpected_done actual=done expected=no_done (cyc %0d)", cyc);
      end else begin
        e8 = q8.pop_front();
        chk("w8_R", 64'(R8), 64'(e8.r));
        chk("w8_flags", 64'(flags8), 64'(e8.f));
        chk("w8_done_cycle", 64'(cyc), 64'(e8.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && done16) begin
      if (q16.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL w16_unexpected_done actual=done expected=no_done (cyc %0d)", cyc);
      end else begin
        e16 = q16.pop_front();
        chk("w16_R", 64'(R16), 64'(e16.r));
        chk("w16_flags", 64'(flags16), 64'(e16.f));
        chk("w16_done_cycle", 64'(cyc), 64'(e16.cyc));
      end
    end
  end

  // Waits for ready, presents one request, and expects done lat edges later.
  task automatic issue8(input logic op, input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] exp_r, input logic [3:0] exp_f,
                        input int lat, input bit push, output logic saw_done);
    int n = 0;
    @(negedge clk);
    while (!ready8 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!ready8) begin
      checks++;
      failures++;
      $display("FAIL w8_ready_timeout actual=0 expected=1 (cyc %0d)", cyc);
    end
    saw_done = done8;
    op8 = op;
    A8 = a;
    B8 = b;
    start8 = 1'b1;
    if (push) q8.push_back(exp_t'{r: 32'(exp_r), f: exp_f, cyc: cyc + lat});
    @(posedge clk);
    #1 start8 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q8.size() != 0 || q16.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() != 0 || q16.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d expected=0 pending", q8.size() + q16.size());
    end
    repeat (2) @(negedge clk);
  endtask

  logic sd;

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_R", 64'(R8), 64'h0);
    chk("reset_flags", 64'(flags8), 64'h0);
    chk("reset_ready", 64'(ready8), 64'h1);
    chk("reset_busy", 64'(busy8), 64'h0);
    chk("reset_done", 64'(done8), 64'h0);

    // MUL 0xFF*0xFF = 0xFE01, S set
    issue8(1'b0, 16'h00FF, 8'hFF, 16'hFE01, 4'b1000, 9, 1'b1, sd);
    @(negedge clk);
    chk("busy_after_accept", 64'(busy8), 64'h1);
    chk("ready_low_in_busy", 64'(ready8), 64'h0);
    drain();

    // DIV 0x1234/0x56 = q 0x36 r 0x10
    issue8(1'b1, 16'h1234, 8'h56, 16'h1036, 4'b0000, 9, 1'b1, sd);
    drain();

    // Divide by zero, then quotient overflow (started in the DONE cycle)
    issue8(1'b1, 16'h1234, 8'h00, 16'h1234, 4'b1100, 1, 1'b1, sd);
    issue8(1'b1, 16'h1234, 8'h12, 16'h1234, 4'b0100, 1, 1'b1, sd);
    drain();

    // Back-to-back: second request issued during the first done cycle
    issue8(1'b0, 16'h0003, 8'h05, 16'h000F, 4'b0000, 9, 1'b1, sd);
    issue8(1'b1, 16'h0064, 8'h0A, 16'h000A, 4'b0000, 9, 1'b1, sd);
    chk("b2b_start_in_done", 64'(sd), 64'h1);
    drain();

    // start during BUSY is ignored; R holds the previous result meanwhile
    issue8(1'b0, 16'h0007, 8'h06, 16'h002A, 4'b0000, 9, 1'b1, sd);
    @(posedge clk);
    @(posedge clk);
    #1;
    op8 = 1'b0;
    A8 = 16'h0002;
    B8 = 8'h02;
    start8 = 1'b1;
    chk("R_held_in_busy", 64'(R8), 64'h000A);
    @(posedge clk);
    #1 start8 = 1'b0;
    drain();

    // Reset 3 cycles into a DIV, with start asserted alongside reset
    issue8(1'b1, 16'h1234, 8'h56, 16'h0, 4'b0, 0, 1'b0, sd);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    start8 = 1'b1;
    op8 = 1'b0;
    A8 = 16'h0003;
    B8 = 8'h03;
    @(posedge clk);
    #1;
    reset = 1'b0;
    start8 = 1'b0;
    @(negedge clk);
    chk("abort_ready", 64'(ready8), 64'h1);
    chk("abort_busy", 64'(busy8), 64'h0);
    chk("abort_R", 64'(R8), 64'h0);
    chk("abort_flags", 64'(flags8), 64'h0);
    chk("abort_done", 64'(done8), 64'h0);
    repeat (15) @(negedge clk);

    // WIDTH=16: 0xFFFF*0xFFFF
    @(negedge clk);
    chk("w16_ready", 64'(ready16), 64'h1);
    op16 = 1'b0;
    A16 = 32'h0000_FFFF;
    B16 = 16'hFFFF;
    start16 = 1'b1;
    q16.push_back(exp_t'{r: 32'hFFFE_0001, f: 4'b1000, cyc: cyc + 17});
    @(posedge clk);
    #1 start16 = 1'b0;
    A16 = '0;
    B16 = '0;
    drain();

    chk("w8_queue_empty", 64'(q8.size()), 64'h0);
    chk("w16_queue_empty", 64'(q16.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
